// File: rtl/queue_enq_arbiter.sv
// queue_enq_arbiter: round-robin arbiter sharing one queue enq port; define QARB_BURST_EN to lock a grant for up to BURST beats
module queue_enq_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH = 16
`ifdef QARB_BURST_EN
    ,
    parameter int BURST = 4
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_bits,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_bits,
    output logic [$clog2(NUM_REQ)-1:0] out_src
);
    localparam int SRC_W = $clog2(NUM_REQ);
    logic [SRC_W-1:0] ptr, off, rr_w, w;
    logic [NUM_REQ-1:0] rot;
    logic [SRC_W:0] sum;
    logic rr_hit, has_w, load_en, fire;
    // valid bits rotated so that bit 0 is the requester at ptr
    assign rot = NUM_REQ'({req_valid, req_valid} >> ptr);
    always_comb begin
        off = '0;
        rr_hit = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                rr_hit = 1'b1;
                off = SRC_W'(k);
            end
        end
    end
    assign sum = {1'b0, ptr} + {1'b0, off};
    assign rr_w = (sum >= (SRC_W+1)'(NUM_REQ)) ? SRC_W'(sum - (SRC_W+1)'(NUM_REQ)) : sum[SRC_W-1:0];
`ifdef QARB_BURST_EN
    logic locked, hold;
    logic [SRC_W-1:0] owner;
    logic [3:0] cnt;
    assign hold = locked && req_valid[owner];
    assign w = hold ? owner : rr_w;
    assign has_w = hold || rr_hit;
    always_ff @(posedge clk) begin
        if (reset) begin
            locked <= 1'b0;
            owner <= '0;
            cnt <= '0;
        end else if (fire && hold) begin
            cnt <= cnt + 4'd1;
            if (cnt + 4'd1 == 4'(BURST)) locked <= 1'b0;
        end else if (fire) begin
            locked <= BURST > 1;
            owner <= w;
            cnt <= 4'd1;
        end else if (!hold) begin
            locked <= 1'b0;
        end
    end
`else
    assign w = rr_w;
    assign has_w = rr_hit;
`endif
    assign load_en = !out_valid || out_ready;
    assign fire = !reset && load_en && has_w;
    assign req_ready = fire ? NUM_REQ'(1) << w : '0;
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_bits <= '0;
            out_src <= '0;
            ptr <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_bits <= req_bits[w*WIDTH +: WIDTH];
            out_src <= w;
            ptr <= (w == SRC_W'(NUM_REQ - 1)) ? '0 : w + 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_queue_enq_arbiter.sv
// tb_queue_enq_arbiter: scoreboard bench for queue_enq_arbiter, 4- and 3-requester instances
module tb_queue_enq_arbiter;
`ifdef QARB_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    logic [3:0] req_valid, req_ready;
    logic [63:0] req_bits;
    logic out_valid, out_ready;
    logic [15:0] out_bits;
    logic [1:0] out_src;
    logic [2:0] req_valid3, req_ready3;
    logic [47:0] req_bits3;
    logic out_valid3, out_ready3;
    logic [15:0] out_bits3;
    logic [1:0] out_src3;
    int total = 0;
    int bad = 0;
    logic [17:0] sb[$];
    logic [17:0] exp_beat;
    queue_enq_arbiter #(.NUM_REQ(4), .WIDTH(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_bits(req_bits), .out_valid(out_valid), .out_ready(out_ready),
        .out_bits(out_bits), .out_src(out_src)
    );
    queue_enq_arbiter #(.NUM_REQ(3), .WIDTH(16)) dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_bits(req_bits3), .out_valid(out_valid3), .out_ready(out_ready3),
        .out_bits(out_bits3), .out_src(out_src3)
    );
    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        req_valid3 = '0;
        out_ready = 1'b1;
        out_ready3 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask
    task automatic test_reset();
        reset = 1'b1;
        req_valid = 4'hF;
        req_valid3 = 3'h7;
        out_ready = 1'b1;
        out_ready3 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (req_ready !== 4'b0 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold4 c=%0d got ready=%b valid=%b want 0000/0", c, req_ready, out_valid);
            end
            total++;
            if (req_ready3 !== 3'b0 || out_valid3 !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold3 c=%0d got ready=%b valid=%b want 000/0", c, req_ready3, out_valid3);
            end
        end
        reset = 1'b0;
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL reset_first_grant got %b want 0001", req_ready);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_src !== 2'd0 || out_bits !== 16'h1000) begin
            bad++;
            $display("FAIL reset_first_beat got v=%b src=%0d bits=%h want 1/0/1000", out_valid, out_src, out_bits);
        end
        req_valid = '0;
        req_valid3 = '0;
    endtask
    task automatic test_rotation();
        do_reset();
        for (int n = 0; n < 6; n++) begin
            int s;
            s = (BURST_ON ? n / 4 : n) % 4;
            sb.push_back({2'(s), 16'h1000 + 16'(s)});
        end
        req_valid = 4'hF;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            exp_beat = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 || {out_src, out_bits} !== exp_beat) begin
                bad++;
                $display("FAIL rotation n=%0d got v=%b src=%0d bits=%h want src=%0d bits=%h", n, out_valid, out_src, out_bits, exp_beat[17:16], exp_beat[15:0]);
            end
            total++;
            if (!$onehot(req_ready)) begin
                bad++;
                $display("FAIL rotation_ready n=%0d got %b want one-hot", n, req_ready);
            end
        end
        req_valid = '0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_bits !== exp_beat[15:0]) begin
            bad++;
            $display("FAIL drain_hold got v=%b bits=%h want 0/%h", out_valid, out_bits, exp_beat[15:0]);
        end
    endtask
    task automatic test_backpressure();
        do_reset();
        req_valid = 4'b0100;
        sb.push_back({2'd2, 16'h1002});
        @(negedge clk);
        exp_beat = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || {out_src, out_bits} !== exp_beat) begin
            bad++;
            $display("FAIL bp_first got v=%b src=%0d bits=%h want 1/2/1002", out_valid, out_src, out_bits);
        end
        req_valid = 4'hF;
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b1 || {out_src, out_bits} !== exp_beat || req_ready !== 4'b0) begin
                bad++;
                $display("FAIL bp_stall c=%0d got v=%b src=%0d bits=%h ready=%b want 1/2/1002/0000", c, out_valid, out_src, out_bits, req_ready);
            end
        end
        out_ready = 1'b1;
        sb.push_back(BURST_ON ? {2'd2, 16'h1002} : {2'd3, 16'h1003});
        #1;
        total++;
        if (req_ready !== (BURST_ON ? 4'b0100 : 4'b1000)) begin
            bad++;
            $display("FAIL bp_release_ready got %b want %b", req_ready, BURST_ON ? 4'b0100 : 4'b1000);
        end
        @(negedge clk);
        exp_beat = sb.pop_front();
        total++;
        if (out_valid !== 1'b1 || {out_src, out_bits} !== exp_beat) begin
            bad++;
            $display("FAIL bp_release got src=%0d bits=%h want src=%0d bits=%h", out_src, out_bits, exp_beat[17:16], exp_beat[15:0]);
        end
        req_valid = '0;
        @(negedge clk);
    endtask
    task automatic test_sparse_wrap();
        do_reset();
        req_valid = 4'b0100;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b1 || out_src !== 2'd2) begin
            bad++;
            $display("FAIL sparse_setup got v=%b src=%0d want 1/2", out_valid, out_src);
        end
        req_valid = 4'b1001;
        for (int n = 0; n < 4; n++) begin
            int s;
            s = (BURST_ON || n % 2 == 0) ? 3 : 0;
            sb.push_back({2'(s), 16'h1000 + 16'(s)});
        end
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            exp_beat = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 || {out_src, out_bits} !== exp_beat) begin
                bad++;
                $display("FAIL sparse n=%0d got v=%b src=%0d bits=%h want src=%0d bits=%h", n, out_valid, out_src, out_bits, exp_beat[17:16], exp_beat[15:0]);
            end
        end
        req_valid = '0;
        @(negedge clk);
    endtask
    task automatic test_non_pow2();
        do_reset();
        for (int n = 0; n < 6; n++) begin
            int s;
            s = (BURST_ON ? n / 4 : n) % 3;
            sb.push_back({2'(s), 16'h1000 + 16'(s)});
        end
        req_valid3 = 3'h7;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            exp_beat = sb.pop_front();
            total++;
            if (out_valid3 !== 1'b1 || out_src3 === 2'd3 || {out_src3, out_bits3} !== exp_beat) begin
                bad++;
                $display("FAIL non_pow2 n=%0d got v=%b src=%0d bits=%h want src=%0d bits=%h", n, out_valid3, out_src3, out_bits3, exp_beat[17:16], exp_beat[15:0]);
            end
        end
        req_valid3 = '0;
        @(negedge clk);
    endtask
`ifdef QARB_BURST_EN
    task automatic test_burst();
        do_reset();
        for (int n = 0; n < 6; n++) sb.push_back({2'(n / 4), 16'h1000 + 16'(n / 4)});
        req_valid = 4'hF;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            exp_beat = sb.pop_front();
            total++;
            if (out_valid !== 1'b1 || {out_src, out_bits} !== exp_beat) begin
                bad++;
                $display("FAIL burst n=%0d got src=%0d bits=%h want src=%0d bits=%h", n, out_src, out_bits, exp_beat[17:16], exp_beat[15:0]);
            end
        end
        req_valid = 4'b1101;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL burst_release_ready got %b want 0100", req_ready);
        end
        @(negedge clk);
        total++;
        if (out_src !== 2'd2 || out_bits !== 16'h1002) begin
            bad++;
            $display("FAIL burst_release got src=%0d bits=%h want 2/1002", out_src, out_bits);
        end
        req_valid = '0;
        @(negedge clk);
    endtask
`endif
    initial begin
        for (int i = 0; i < 4; i++) req_bits[i*16 +: 16] = 16'h1000 + 16'(i);
        for (int i = 0; i < 3; i++) req_bits3[i*16 +: 16] = 16'h1000 + 16'(i);
        test_reset();
        test_rotation();
        test_backpressure();
        test_sparse_wrap();
        test_non_pow2();
`ifdef QARB_BURST_EN
        test_burst();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
